// File: rtl/expr_checker.sv
// ---------------------------------------------------------------------------
// expr_checker
//
// Serial recognizer for arithmetic expressions of the form D (OP D)*.
// D is a decimal digit. OP is '+' or '*', and also '-' when EXPR_SUB_EN is
// defined. The block consumes one ASCII character on every rising clock edge
// where clr is low.
//
// Optional feature macro: EXPR_SUB_EN
//   defined   : '-' (8'h2D) is an operator, with the same transitions as '+'.
//   undefined : '-' is an ordinary invalid character and leads to ERR.
//
// Parameters:
//   MULTI_DIGIT : 0 = each operand is exactly one digit.
//                 1 = an operand is one or more consecutive digits.
//
// Ports:
//   clk : system clock. All state changes happen on the rising edge.
//   clr : synchronous active-high clear. It starts a new expression, and the
//         character present on the same edge is discarded.
//   in  : ASCII character, sampled on every rising edge where clr=0.
//   out : 1 while the characters since clear form a complete valid expression.
//   err : 1 once the sequence is irrecoverably invalid. It stays set until clr.
//
// Flow control: there is no valid/ready handshake. Every rising edge with
// clr=0 consumes exactly one character, and in must be stable around that edge.
// out and err are decoded only from the state register, so there is no
// combinational path from in to either output.
// ---------------------------------------------------------------------------
module expr_checker #(
  parameter int MULTI_DIGIT = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  output logic       out,
  output logic       err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing accepted since clear
    NUM   = 2'd1,  // last character was a digit, so the expression is complete
    OPR   = 2'd2,  // last character was an operator, so the expression is incomplete
    ERR   = 2'd3   // invalid; only clr leaves this state
  } state_t;

  // Held in a named register so checkers can probe the state hierarchically.
  state_t state;
  state_t state_nxt;

  logic is_digit;
  logic is_op;

  // Character classification
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
`ifdef EXPR_SUB_EN
    is_op    = (in == 8'h2B) || (in == 8'h2A) || (in == 8'h2D);
`else
    is_op    = (in == 8'h2B) || (in == 8'h2A);
`endif
  end

  // State register. clr has priority over the character on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = ERR;
    case (state)
      EMPTY: begin
        if (is_digit) state_nxt = NUM;
        else          state_nxt = ERR;
      end
      NUM: begin
        if (is_op)                              state_nxt = OPR;
        else if (is_digit && MULTI_DIGIT != 0)  state_nxt = NUM;
        else                                    state_nxt = ERR;
      end
      OPR: begin
        if (is_digit) state_nxt = NUM;
        else          state_nxt = ERR;
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = ERR;
      end
    endcase
  end

  // Moore outputs decoded from the state register
  assign out = (state == NUM);
  assign err = (state == ERR);

endmodule

// File: tb/tb_expr_checker.sv
// ---------------------------------------------------------------------------
// tb_expr_checker
//
// Bench for expr_checker. Two instances share clk, clr and in: one with
// MULTI_DIGIT=0 and one with MULTI_DIGIT=1. Each driven character pushes the
// expected {out0, err0, out1, err1} onto exp_q. After the edge, the value is
// popped and compared with the outputs of both instances.
// ---------------------------------------------------------------------------
module tb_expr_checker;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       clr;
  logic [7:0] in;
  logic       out0, err0, out1, err1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expr_checker #(.MULTI_DIGIT(0)) dut (
    .clk (clk), .clr (clr), .in (in), .out (out0), .err (err0)
  );

  expr_checker #(.MULTI_DIGIT(1)) dut_md (
    .clk (clk), .clr (clr), .in (in), .out (out1), .err (err1)
  );

  // ---------------- reference model ----------------
  // States: 0 empty, 1 number, 2 operator, 3 error
  int m0_st;
  int m1_st;

  function automatic bit c_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit c_op(input logic [7:0] c);
`ifdef EXPR_SUB_EN
    return (c == "+") || (c == "*") || (c == "-");
`else
    return (c == "+") || (c == "*");
`endif
  endfunction

  function automatic int model_next(input int st, input logic [7:0] c, input bit md);
    if (st == 0) return c_digit(c) ? 1 : 3;
    if (st == 1) begin
      if (c_op(c)) return 2;
      if (c_digit(c) && md) return 1;
      return 3;
    end
    if (st == 2) return c_digit(c) ? 1 : 3;
    return 3;
  endfunction

  function automatic logic [1:0] model_out(input int st);
    return {st == 1, st == 3};
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {out0,err0,out1,err1}=%b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sample(input string tag);
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {out0, err0, out1, err1}, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_clear(input string tag);
    @(negedge clk);
    clr = 1'b1;
    in  = 8'($urandom_range(0, 255));  // this character must be ignored
    m0_st = 0;
    m1_st = 0;
    exp_q.push_back({model_out(m0_st), model_out(m1_st)});
    sample(tag);
  endtask

  task automatic send(input logic [7:0] c, input string tag);
    @(negedge clk);
    clr = 1'b0;
    in  = c;
    m0_st = model_next(m0_st, c, 1'b0);
    m1_st = model_next(m1_st, c, 1'b1);
    exp_q.push_back({model_out(m0_st), model_out(m1_st)});
    sample(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], tag);
  endtask

  // Directed check against values derived by hand for the single-digit instance.
  task automatic expect_md0(input string tag, input logic o, input logic e);
    check(tag, {out0, err0, 2'b00}, {o, e, 2'b00});
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    logic [7:0] digs;
    digs = "0";
    k = $urandom_range(0, 9);
    if (k < 5) return digs + 8'($urandom_range(0, 9));
    if (k == 5) return "+";
    if (k == 6) return "*";
    if (k == 7) return "-";
    if (k == 8) return "A";
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    clr   = 1'b1;
    in    = 8'h00;
    m0_st = 0;
    m1_st = 0;

    do_clear("reset");
    expect_md0("reset_direct", 1'b0, 1'b0);

    // Main sequence: out should read 1,0,1,0,1,0,1 with err low throughout.
    send("1", "seq_1");  expect_md0("seq_1_direct", 1'b1, 1'b0);
    send("+", "seq_p");  expect_md0("seq_p_direct", 1'b0, 1'b0);
    send_str("2+3*4", "seq_main");
    expect_md0("seq_end_direct", 1'b1, 1'b0);
    // Holding '4' for one more edge counts as a second digit.
    send("4", "held_digit");
    expect_md0("held_digit_direct", 1'b0, 1'b1);
    send_str("+5", "sticky_err");
    expect_md0("sticky_direct", 1'b0, 1'b1);

    // A leading operator is an error. Clearing must recover from it.
    do_clear("clr2");
    send("+", "lead_op");
    expect_md0("lead_op_direct", 1'b0, 1'b1);
    do_clear("clr_from_err");
    expect_md0("clr_from_err_direct", 1'b0, 1'b0);
    send("7", "after_clr");
    expect_md0("after_clr_direct", 1'b1, 1'b0);

    // Two operators in a row
    do_clear("clr3");
    send_str("3**", "double_op");
    expect_md0("double_op_direct", 1'b0, 1'b1);

    // Invalid character
    do_clear("clr4");
    send_str("3A", "other_char");
    expect_md0("other_direct", 1'b0, 1'b1);

    // Multi-digit operands (the MULTI_DIGIT=1 instance): out 1,1,0,1,1
    do_clear("clr5");
    send_str("12+34", "multi_digit");
    check("multi_digit_direct", {out1, err1, 2'b00}, 4'b1000);

    // Subtraction operator
    do_clear("clr6");
    send_str("9-", "sub");
`ifdef EXPR_SUB_EN
    expect_md0("sub_op_direct", 1'b0, 1'b0);
    send("1", "sub_end");
    expect_md0("sub_end_direct", 1'b1, 1'b0);
`else
    expect_md0("sub_err_direct", 1'b0, 1'b1);
`endif

    // Boundary characters just outside the digit range
    do_clear("clr7");
    send(8'h2F, "below_0");
    do_clear("clr8");
    send(8'h3A, "above_9");
    do_clear("clr9");
    send_str("0+9", "edge_digits");

    // Random stream with occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) do_clear("rand_clr");
      else send(rand_char(), "rand");
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/expr_checker.md
Name: expr_checker

Overview:
- Serial recognizer for arithmetic expressions of the form `D (OP D)*`, where D is a single decimal digit and OP is `+` or `*`.
- One ASCII character is sampled per clock edge from an 8-bit stream.
- Asserts `out` while the characters accepted since the last clear form a complete, valid expression.
- Sits at the front of a character-stream parser; `clr` starts a new expression.

Parameters:
- MULTI_DIGIT, default 0. 0: every operand is exactly one digit. 1: an operand is one or more consecutive digits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset/clear; restarts recognition.
- in  input  8  ASCII character, sampled on every rising edge where clr=0.
- out  output  1  registered; 1 = the sequence since clear is a complete valid expression.
- err  output  1  registered; 1 = the sequence is irrecoverably invalid (sticky until clr).

Behaviour:
- Character classes:
  - DIGIT: 8'h30..8'h39.
  - OP: 8'h2B `+` and 8'h2A `*`, plus 8'h2D `-` only when the optional feature is enabled.
  - Any other byte is OTHER.
- States (Moore FSM, one character consumed per clock):
  - EMPTY: no characters since clear.
  - NUM: last accepted character is a digit, so the expression is complete.
  - OPR: last accepted character is an operator, so the expression is incomplete.
  - ERR: invalid.
- Transitions on each rising edge with clr=0:
  - EMPTY: DIGIT -> NUM; OP or OTHER -> ERR.
  - NUM: OP -> OPR; DIGIT -> NUM if MULTI_DIGIT=1, else ERR; OTHER -> ERR.
  - OPR: DIGIT -> NUM; OP or OTHER -> ERR.
  - ERR: stays in ERR for any input.
- Outputs: out=1 only in NUM; err=1 only in ERR. Both are decoded from the state register, so there are no combinational paths from `in`.
- Latency: the character sampled at edge k is reflected on out/err immediately after edge k.
- Reset: clr=1 at a rising edge puts the FSM in EMPTY with out=0 and err=0, regardless of `in`. clr has priority over the character present on that edge, and that character is discarded.
- clr takes effect on the next rising edge only; there is no asynchronous path.
- A held input is re-sampled every cycle. A digit held for two edges is therefore two digits (ERR when MULTI_DIGIT=0).
- Power-up state before the first clr is undefined; the bench must clear first, or treat the expression as starting at the first sampled edge if initialised to EMPTY.
- `in` must be stable around the rising edge. No handshake; every edge with clr=0 consumes a character.

Optional Feature:
- Macro EXPR_SUB_EN.
- Defined: `-` (8'h2D) is an OP, with the same transitions as `+` and `*`.
- Undefined: `-` is OTHER and drives the FSM to ERR.

Test Plan:
- clr=1 for one edge, then "1","+","2","+","3","*","4", one per edge -> out sequence 1,0,1,0,1,0,1; err=0 throughout.
- After the previous sequence, hold "4" for one more edge (MULTI_DIGIT=0) -> out=0, err=1; further inputs keep err=1 until clr.
- From clear, first char "+" -> err=1, out=0. Then clr=1 -> out=0, err=0. Then "7" -> out=1.
- "3","*","*" -> out 1,0,0; err set on the second "*". Same with "3","A" -> err on "A".
- MULTI_DIGIT=1: "1","2","+","3","4" -> out 1,1,0,1,1.
- With EXPR_SUB_EN defined, "9","-","1" -> out 1,0,1. Without the macro -> err=1 after "-".
